dac_spi_tx: RTL and testbench



---
 rtl/dac_spi_tx.sv | 126 ++++++++++++
 tb/tb_dac_spi_tx.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_spi_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dac_spi_tx                                                                 |
// | Serial DAC transmitter (DIN/SCLK/SYNC) fed by a valid/ready sample source, |
// | with a one-word holding buffer so frames can run back to back.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module dac_spi_tx #(
   parameter int DATA_W   = 16,
   parameter int CLK_DIV  = 2,
   parameter int SYNC_GAP = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic              dac_sync,
   output logic              dac_clk,
   output logic              dac_din,
   output logic              busy,
   output logic              frame_done
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W = $clog2(DATA_W);
   localparam int GAP_W = (SYNC_GAP > 1) ? $clog2(SYNC_GAP) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(SYNC_GAP - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } state_t;

   state_t            state;
   logic [DATA_W-1:0] hold_data;
   logic              hold_full;
   logic [DATA_W-1:0] shifter;
   logic [DIV_W-1:0]  div_cnt;
   logic [BIT_W-1:0]  bit_cnt;
   logic [GAP_W-1:0]  gap_cnt;
   logic              accept;
   logic              load;

   assign s_ready = ~hold_full & ~rst;
   assign accept  = s_valid & s_ready;
   assign load    = hold_full & ((state == IDLE) | ((state == GAP) & (gap_cnt == GAP_LAST)));
   assign busy    = (state != IDLE) | hold_full;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_data <= '0;
         hold_full <= 1'b0;
      end else if (accept) begin
         hold_data <= s_data;
         hold_full <= 1'b1;
      end else if (load) begin
         hold_full <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         shifter    <= '0;
         div_cnt    <= '0;
         bit_cnt    <= '0;
         gap_cnt    <= '0;
         dac_sync   <= 1'b1;
         dac_clk    <= 1'b1;
         dac_din    <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (load) begin
            state    <= SHIFT;
            shifter  <= hold_data;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            dac_sync <= 1'b0;
            dac_clk  <= 1'b1;
            dac_din  <= hold_data[DATA_W-1];
         end else begin
            case (state)
               IDLE: ;
               SHIFT: begin
                  if (div_cnt == DIV_LAST) begin
                     div_cnt <= '0;
                     if (dac_clk) begin
                        dac_clk <= 1'b0;
                     end else if (bit_cnt < BIT_LAST) begin
                        // Data moves only together with the rising SCLK edge.
                        shifter <= {shifter[DATA_W-2:0], 1'b0};
                        bit_cnt <= bit_cnt + 1'b1;
                        dac_clk <= 1'b1;
                        dac_din <= shifter[DATA_W-2];
                     end else begin
                        state      <= GAP;
                        gap_cnt    <= '0;
                        frame_done <= 1'b1;
                        dac_sync   <= 1'b1;
                        dac_clk    <= 1'b1;
                        dac_din    <= 1'b0;
                     end
                  end else begin
                     div_cnt <= div_cnt + 1'b1;
                  end
               end
               GAP: begin
                  if (gap_cnt == GAP_LAST) begin
                     state <= IDLE;
                  end else begin
                     gap_cnt <= gap_cnt + 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dac_spi_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dac_spi_tx                                                              |
// | Self-checking bench for dac_spi_tx (default and 24-bit/fast instances).    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_dac_spi_tx;
   localparam int DW = 16, CD = 2, SG = 4;
   localparam int FRAME = 2 * CD * DW, PERIOD = FRAME + SG;
   localparam int DW2 = 24, CD2 = 1, SG2 = 1;
   localparam int FRAME2 = 2 * CD2 * DW2;

   logic clk = 1'b0, rst = 1'b0;
   logic [DW-1:0]  s_data = '0;
   logic           s_valid = 1'b0;
   logic           s_ready, dac_sync, dac_clk, dac_din, busy, frame_done;
   logic [DW2-1:0] s_data2 = '0;
   logic           s_valid2 = 1'b0;
   logic           s_ready2, dac_sync2, dac_clk2, dac_din2, busy2, frame_done2;

   dac_spi_tx #(.DATA_W(DW), .CLK_DIV(CD), .SYNC_GAP(SG)) dut (
      .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .dac_sync(dac_sync), .dac_clk(dac_clk), .dac_din(dac_din), .busy(busy),
      .frame_done(frame_done));

   dac_spi_tx #(.DATA_W(DW2), .CLK_DIV(CD2), .SYNC_GAP(SG2)) dut2 (
      .clk(clk), .rst(rst), .s_data(s_data2), .s_valid(s_valid2), .s_ready(s_ready2),
      .dac_sync(dac_sync2), .dac_clk(dac_clk2), .dac_din(dac_din2), .busy(busy2),
      .frame_done(frame_done2));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] word;
      int          nbits;
      int          len;
      int          start;
      int          gap;
   } frame_t;

   frame_t      frames[$];
   logic [31:0] exp_q[$];
   int          checks = 0, errors = 0;

   // Line observer: reconstructs each frame as the DAC would see it.
   logic        p_sync[2] = '{1'b1, 1'b1};
   logic        p_clk[2]  = '{1'b1, 1'b1};
   logic        p_din[2]  = '{1'b0, 1'b0};
   logic [31:0] cap[2];
   int          nb[2], ln[2], fall_cyc[2], rise_cyc[2], gap_len[2];
   int          fd_cnt[2], fd_bad[2], din_bad[2];
   initial begin
      for (int i = 0; i < 2; i++) begin
         cap[i] = 0; nb[i] = 0; ln[i] = 0; fall_cyc[i] = 0; rise_cyc[i] = 0;
         gap_len[i] = 0; fd_cnt[i] = 0; fd_bad[i] = 0; din_bad[i] = 0;
      end
   end

   always @(negedge clk) begin : mon
      logic   sy, sc, sd, fd;
      frame_t f;
      for (int i = 0; i < 2; i++) begin
         sy = (i == 0) ? dac_sync : dac_sync2;
         sc = (i == 0) ? dac_clk : dac_clk2;
         sd = (i == 0) ? dac_din : dac_din2;
         fd = (i == 0) ? frame_done : frame_done2;
         if (sy == 1'b0) begin
            if (p_sync[i]) begin
               cap[i] = 0; nb[i] = 0; ln[i] = 0; fall_cyc[i] = cyc;
               gap_len[i] = cyc - rise_cyc[i];
            end
            ln[i]++;
            if (p_clk[i] && !sc) begin
               cap[i] = {cap[i][30:0], sd};
               nb[i]++;
            end
            if (!p_sync[i] && (sd != p_din[i]) && !(!p_clk[i] && sc)) din_bad[i]++;
         end else if (!p_sync[i]) begin
            f.word = cap[i]; f.nbits = nb[i]; f.len = ln[i];
            f.start = fall_cyc[i]; f.gap = gap_len[i];
            frames.push_back(f);
            rise_cyc[i] = cyc;
         end
         if (fd) begin
            fd_cnt[i]++;
            if (!(sy && !p_sync[i])) fd_bad[i]++;
         end
         p_sync[i] = sy; p_clk[i] = sc; p_din[i] = sd;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int id, input logic [31:0] w, output int acc);
      logic rdy;
      if (id == 0) begin s_data = w[DW-1:0]; s_valid = 1'b1; end
      else begin s_data2 = w[DW2-1:0]; s_valid2 = 1'b1; end
      acc = -1;
      for (int n = 0; n < 500 && acc < 0; n++) begin
         rdy = (id == 0) ? s_ready : s_ready2;
         tick();
         if (rdy) acc = cyc;
      end
      checks++;
      if (acc < 0) begin
         errors++;
         $display("FAIL accept_timeout: word %h got no acceptance, required acceptance within 500 cycles", w);
      end else begin
         exp_q.push_back(w);
      end
   endtask

   task automatic wait_frames(input int n, output bit to);
      to = 1'b1;
      for (int k = 0; k < 3000 && to; k++) begin
         if (frames.size() >= n) to = 1'b0;
         else tick();
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({dac_sync, dac_clk, dac_din, s_ready, busy, frame_done} !== 6'b110000) begin
         errors++;
         $display("FAIL reset_outputs: sync/clk/din/ready/busy/done got %b required 110000",
                  {dac_sync, dac_clk, dac_din, s_ready, busy, frame_done});
      end
      repeat (3) tick();
      rst = 1'b0;
      tick();
      checks++;
      if ({s_ready, busy, dac_sync, s_ready2, busy2} !== 5'b10110) begin
         errors++;
         $display("FAIL reset_release: ready/busy/sync/ready2/busy2 got %b required 10110",
                  {s_ready, busy, dac_sync, s_ready2, busy2});
      end
   endtask

   task automatic test_single();
      int acc, fd0;
      bit to;
      frames.delete(); exp_q.delete();
      fd0 = fd_cnt[0];
      send(0, 32'hA5C3, acc);
      s_valid = 1'b0;
      checks++;
      if ({s_ready, busy} !== 2'b01) begin
         errors++;
         $display("FAIL single_accept: ready/busy got %b required 01", {s_ready, busy});
      end
      tick();
      checks++;
      if ({dac_sync, s_ready, dac_din, dac_clk} !== 4'b0111) begin
         errors++;
         $display("FAIL single_load: sync/ready/din/clk got %b required 0111",
                  {dac_sync, s_ready, dac_din, dac_clk});
      end
      for (int k = 0; k < FRAME + 10 && dac_sync === 1'b0; k++) tick();
      checks++;
      if ({dac_sync, frame_done, busy} !== 3'b111) begin
         errors++;
         $display("FAIL single_gap_start: sync/done/busy got %b required 111",
                  {dac_sync, frame_done, busy});
      end
      repeat (SG - 1) tick();
      checks++;
      if ({busy, frame_done} !== 2'b10) begin
         errors++;
         $display("FAIL single_gap_busy: busy/done got %b required 10", {busy, frame_done});
      end
      tick();
      checks++;
      if ({busy, dac_sync} !== 2'b01) begin
         errors++;
         $display("FAIL single_idle: busy/sync got %b required 01", {busy, dac_sync});
      end
      wait_frames(1, to);
      checks++;
      if (to || frames[0].word !== 32'hA5C3 || frames[0].nbits != DW || frames[0].len != FRAME
          || frames[0].start != acc + 1) begin
         errors++;
         $display("FAIL single_frame: timeout=%0d word %h bits %0d len %0d start %0d required A5C3 %0d %0d %0d",
                  to, to ? 32'h0 : frames[0].word, to ? 0 : frames[0].nbits,
                  to ? 0 : frames[0].len, to ? 0 : frames[0].start, DW, FRAME, acc + 1);
      end
      checks++;
      if (fd_cnt[0] - fd0 != 1) begin
         errors++;
         $display("FAIL single_done_count: got %0d pulses required 1", fd_cnt[0] - fd0);
      end
   endtask

   task automatic test_back_to_back();
      int a1, a2;
      bit to;
      frames.delete(); exp_q.delete();
      send(0, 32'h0001, a1);
      send(0, 32'hFFFF, a2);
      s_valid = 1'b0;
      checks++;
      if (a2 != a1 + 2) begin
         errors++;
         $display("FAIL b2b_accept: second accept at %0d required %0d", a2, a1 + 2);
      end
      wait_frames(2, to);
      checks++;
      if (to) begin
         errors++;
         $display("FAIL b2b_timeout: got %0d frames required 2", frames.size());
      end else begin
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (frames[k].word !== exp_q[k] || frames[k].nbits != DW || frames[k].len != FRAME) begin
               errors++;
               $display("FAIL b2b_frame%0d: word %h bits %0d len %0d required %h %0d %0d",
                        k, frames[k].word, frames[k].nbits, frames[k].len, exp_q[k], DW, FRAME);
            end
         end
         checks++;
         if (frames[1].gap != SG || frames[1].start - frames[0].start != PERIOD) begin
            errors++;
            $display("FAIL b2b_spacing: gap %0d spacing %0d required %0d %0d",
                     frames[1].gap, frames[1].start - frames[0].start, SG, PERIOD);
         end
      end
      repeat (SG + 2) tick();
   endtask

   task automatic test_backpressure();
      int a[4];
      logic [31:0] w[4];
      bit to;
      frames.delete(); exp_q.delete();
      for (int k = 0; k < 4; k++) w[k] = {16'h0, 16'($urandom)};
      send(0, w[0], a[0]);
      send(0, w[1], a[1]);
      send(0, w[2], a[2]);
      checks++;
      if (a[2] != a[0] + PERIOD + 2) begin
         errors++;
         $display("FAIL bp_stall: third accept at %0d required %0d", a[2], a[0] + PERIOD + 2);
      end
      s_valid = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
      send(0, w[3], a[3]);
      s_valid = 1'b0;
      wait_frames(4, to);
      repeat (PERIOD + 10) tick();
      checks++;
      if (to || frames.size() != 4) begin
         errors++;
         $display("FAIL bp_count: got %0d frames required 4", frames.size());
      end else begin
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (frames[k].word !== exp_q[k] || frames[k].len != FRAME) begin
               errors++;
               $display("FAIL bp_frame%0d: word %h len %0d required %h %0d",
                        k, frames[k].word, frames[k].len, exp_q[k], FRAME);
            end
         end
      end
      checks++;
      if (din_bad[0] != 0 || fd_bad[0] != 0) begin
         errors++;
         $display("FAIL line_rules: din changes off rising edge %0d, misplaced frame_done %0d, required 0 0",
                  din_bad[0], fd_bad[0]);
      end
   endtask

   task automatic test_reset_mid();
      int a, b, fd0;
      bit to;
      frames.delete(); exp_q.delete();
      send(0, 32'hFFFF, a);
      send(0, 32'h5555, b);
      s_valid = 1'b0;
      for (int k = 0; k < 100 && cyc < a + 1 + 30; k++) tick();
      fd0 = fd_cnt[0];
      rst = 1'b1;
      #1;
      checks++;
      if ({dac_sync, dac_clk, dac_din, s_ready, busy, frame_done} !== 6'b110000) begin
         errors++;
         $display("FAIL midreset_outputs: sync/clk/din/ready/busy/done got %b required 110000",
                  {dac_sync, dac_clk, dac_din, s_ready, busy, frame_done});
      end
      tick(); tick();
      rst = 1'b0;
      repeat (20) tick();
      checks++;
      if (fd_cnt[0] != fd0 || busy !== 1'b0 || dac_sync !== 1'b1) begin
         errors++;
         $display("FAIL midreset_abandon: done pulses %0d busy %b sync %b required 0 0 1",
                  fd_cnt[0] - fd0, busy, dac_sync);
      end
      frames.delete(); exp_q.delete();
      send(0, 32'h1234, a);
      s_valid = 1'b0;
      wait_frames(1, to);
      checks++;
      if (to || frames[0].word !== 32'h1234 || frames[0].nbits != DW || frames[0].len != FRAME) begin
         errors++;
         $display("FAIL midreset_resume: timeout=%0d word %h required 1234",
                  to, to ? 32'h0 : frames[0].word);
      end
      repeat (SG + 2) tick();
   endtask

   task automatic test_wide();
      int a, b;
      logic [31:0] w2;
      bit to;
      frames.delete(); exp_q.delete();
      w2 = {8'h0, 24'($urandom)};
      send(1, 32'h800001, a);
      send(1, w2, b);
      s_valid2 = 1'b0;
      wait_frames(2, to);
      checks++;
      if (to) begin
         errors++;
         $display("FAIL wide_timeout: got %0d frames required 2", frames.size());
      end else begin
         checks++;
         if (frames[0].word !== 32'h800001 || frames[0].nbits != DW2 || frames[0].len != FRAME2
             || frames[0].start != a + 1) begin
            errors++;
            $display("FAIL wide_frame0: word %h bits %0d len %0d start %0d required 800001 %0d %0d %0d",
                     frames[0].word, frames[0].nbits, frames[0].len, frames[0].start,
                     DW2, FRAME2, a + 1);
         end
         checks++;
         if (frames[1].word !== w2 || frames[1].gap != SG2
             || frames[1].start - frames[0].start != FRAME2 + SG2) begin
            errors++;
            $display("FAIL wide_frame1: word %h gap %0d spacing %0d required %h %0d %0d",
                     frames[1].word, frames[1].gap, frames[1].start - frames[0].start,
                     w2, SG2, FRAME2 + SG2);
         end
      end
      checks++;
      if (din_bad[1] != 0 || fd_bad[1] != 0 || fd_cnt[1] != 2) begin
         errors++;
         $display("FAIL wide_rules: din violations %0d done misplaced %0d done pulses %0d required 0 0 2",
                  din_bad[1], fd_bad[1], fd_cnt[1]);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      test_wide();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
